// File: rtl/nios_fprint_sys_info.sv
// System-identification and uptime register file on an Avalon-MM slave port.
// Optional 64-bit uptime counter, shadow_hi and CTRL are built only when NIOS_FPRINT_SYSID_UPTIME_EN is defined.
module nios_fprint_sys_info #(
  parameter logic [31:0] ID_VALUE        = 32'h556CC289,
  parameter logic [31:0] TIMESTAMP_VALUE = 32'd0,
  parameter int unsigned NUM_CORES       = 4,
  parameter logic [7:0]  HW_VERSION      = 8'd2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        readdatavalid
);

  // Handshake: no waitrequest. A read strobe sampled at a clock edge yields
  // readdatavalid=1 with readdata for exactly the following cycle; readdata
  // holds otherwise. A write colliding with a read is dropped.

  localparam logic [7:0] CORES = 8'(NUM_CORES);
`ifdef NIOS_FPRINT_SYSID_UPTIME_EN
  localparam logic UPTIME_CAP = 1'b1;
`else
  localparam logic UPTIME_CAP = 1'b0;
`endif
  localparam logic [31:0] CAPS_VALUE = {15'd0, UPTIME_CAP, HW_VERSION, CORES};

  logic [31:0] scratch;
  logic [31:0] rd_mux;
  logic        wr_ok;

  assign wr_ok = write & ~read;

`ifdef NIOS_FPRINT_SYSID_UPTIME_EN
  logic [63:0] uptime;
  logic [31:0] shadow_hi;
  logic        en;
  logic        ctrl_wr;

  assign ctrl_wr = wr_ok && (address == 3'd6);

  // CLR beats the increment; EN is updated by the same CTRL write.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      uptime    <= '0;
      shadow_hi <= '0;
      en        <= 1'b1;
    end else begin
      if (ctrl_wr && writedata[1]) uptime <= '0;
      else if (en)                 uptime <= uptime + 64'd1;
      if (ctrl_wr) en <= writedata[0];
      // Snapshot the high half from the same pre-increment sample as LO.
      if (read && (address == 3'd4)) shadow_hi <= uptime[63:32];
    end
  end
`endif

  always_comb begin
    rd_mux = '0;
    case (address)
      3'd0: rd_mux = ID_VALUE;
      3'd1: rd_mux = TIMESTAMP_VALUE;
      3'd2: rd_mux = CAPS_VALUE;
      3'd3: rd_mux = scratch;
`ifdef NIOS_FPRINT_SYSID_UPTIME_EN
      3'd4: rd_mux = uptime[31:0];
      3'd5: rd_mux = shadow_hi;
      3'd6: rd_mux = {31'd0, en};
`endif
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scratch       <= '0;
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= read;
      if (read) readdata <= rd_mux;
      if (wr_ok && (address == 3'd3)) scratch <= writedata;
    end
  end

endmodule

// File: tb/tb_nios_fprint_sys_info.sv
// Directed scoreboard bench for nios_fprint_sys_info; covers both builds of NIOS_FPRINT_SYSID_UPTIME_EN.
module tb_nios_fprint_sys_info;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        readdatavalid;

  logic [31:0] exp_q[$];
  logic [31:0] exp_v;
  int          n_vec = 0;
  int          n_err = 0;

  nios_fprint_sys_info dut (
    .clock(clock),
    .reset(reset),
    .address(address),
    .read(read),
    .write(write),
    .writedata(writedata),
    .readdata(readdata),
    .readdatavalid(readdatavalid)
  );

  // clock / reset
  always #5 clock = ~clock;

  // driver tasks: inputs change 1ns after the rising edge
  task automatic do_read(input logic [2:0] a, input logic [31:0] e);
    address = a; read = 1'b1; write = 1'b0;
    exp_q.push_back(e);
    @(posedge clock); #1;
    read = 1'b0;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1'b1; read = 1'b0;
    @(posedge clock); #1;
    write = 1'b0;
  endtask

  task automatic do_read_write(input logic [2:0] a, input logic [31:0] d, input logic [31:0] e);
    address = a; writedata = d; write = 1'b1; read = 1'b1;
    exp_q.push_back(e);
    @(posedge clock); #1;
    write = 1'b0; read = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clock) begin
    if (readdatavalid === 1'b1) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_valid: got data 0x%08h with no read outstanding", readdata);
      end else begin
        exp_v = exp_q.pop_front();
        if (readdata !== exp_v) begin
          n_err++;
          $display("FAIL readdata: got 0x%08h expected 0x%08h", readdata, exp_v);
        end
      end
    end
  end

  initial begin
    logic [31:0] caps_exp;
`ifdef NIOS_FPRINT_SYSID_UPTIME_EN
    caps_exp = 32'h00010204;
`else
    caps_exp = 32'h00000204;
`endif

    @(negedge clock);
    check("reset_readdata", readdata, 32'h0);
    check("reset_valid", {31'd0, readdatavalid}, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;

    // identification words back-to-back
    do_read(3'd0, 32'h556CC289);
    do_read(3'd1, 32'h00000000);
    do_read(3'd2, caps_exp);
    idle(1);

    // scratch and RO write protection
    do_read(3'd3, 32'h00000000);
    do_write(3'd3, 32'hDEADBEEF);
    do_read(3'd3, 32'hDEADBEEF);
    do_write(3'd0, 32'h12345678);
    do_read(3'd0, 32'h556CC289);
    do_write(3'd2, 32'hFFFFFFFF);
    do_read(3'd2, caps_exp);
    do_write(3'd7, 32'hFFFFFFFF);
    do_read(3'd7, 32'h00000000);

`ifdef NIOS_FPRINT_SYSID_UPTIME_EN
    // LO read snapshots the high half before the carry lands
    force dut.uptime = 64'h00000000_FFFFFFFF;
    do_read(3'd4, 32'hFFFFFFFF);
    release dut.uptime;
    do_read(3'd5, 32'h00000000);

    // clear+run, then freeze one cycle later at 1
    do_write(3'd6, 32'h3);
    do_write(3'd6, 32'h0);
    idle(100);
    do_read(3'd4, 32'h00000001);
    do_read(3'd4, 32'h00000001);
    do_read(3'd5, 32'h00000000);
    do_read(3'd6, 32'h00000000);

    // clear with EN, counter runs from 0
    do_write(3'd6, 32'h3);
    do_read(3'd4, 32'h00000000);
    do_read(3'd4, 32'h00000001);
    do_read(3'd6, 32'h00000001);
`else
    do_write(3'd4, 32'hFFFFFFFF);
    do_write(3'd6, 32'h3);
    do_read(3'd4, 32'h00000000);
    do_read(3'd5, 32'h00000000);
    do_read(3'd6, 32'h00000000);
`endif

    // collision: read wins, write dropped
    do_read_write(3'd3, 32'hA5A5A5A5, 32'hDEADBEEF);
    do_read(3'd3, 32'hDEADBEEF);
    idle(2);

    // reset right after a sampled read cancels its response
    address = 3'd3; read = 1'b1;
    @(posedge clock); #1;
    read = 1'b0; reset = 1'b1;
    @(negedge clock);
    check("abort_valid", {31'd0, readdatavalid}, 32'h0);
    check("abort_readdata", readdata, 32'h0);
    @(posedge clock); #1;
    reset = 1'b0;
    do_read(3'd3, 32'h00000000);

    // drain with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clock);
    @(negedge clock);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
